// File: rtl/mcu_spi_target.sv
// SPI mode-0 target for the MCU link: oversamples SCK/SS/MOSI, assembles bytes,
// routes each frame to the target named by its first byte, and returns that target's reply on MISO.
module mcu_spi_target #(
   parameter int                 DATA_W = 8,
   parameter logic [DATA_W-1:0]  SYS_ID = 8'd1,
   parameter logic [DATA_W-1:0]  HID_ID = 8'd2,
   parameter logic [DATA_W-1:0]  OSD_ID = 8'd3,
   parameter logic [DATA_W-1:0]  SDC_ID = 8'd4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              spi_ss_n,
   input  logic              spi_sck,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic [DATA_W-1:0] data_out,
   output logic              data_start,
   output logic              sys_strobe,
   output logic              hid_strobe,
   output logic              osd_strobe,
   output logic              sdc_strobe,
   input  logic [DATA_W-1:0] sys_din,
   input  logic [DATA_W-1:0] hid_din,
   input  logic [DATA_W-1:0] osd_din,
   input  logic [DATA_W-1:0] sdc_din
);

   localparam int               CNT_W    = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SELECT  = 3'd1,
      CMD     = 3'd2,
      DATA    = 3'd3,
      DISCARD = 3'd4
   } state_t;

   state_t state_q, state_d;

   logic ss_p0, ss_p1, ss_p2;
   logic sck_p0, sck_p1, sck_p2;
   logic mosi_p0, mosi_p1;

   logic [CNT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] rx;
   logic [DATA_W-1:0] rx_next;
   logic [DATA_W-1:0] tx;
   logic [DATA_W-1:0] din_sel;

   logic       sck_rise, sck_fall, ss_fall;
   logic       byte_done;
   logic       strobe_en, start_d;
   logic       id_hit;
   logic [1:0] id_idx;
   logic [1:0] sel_idx;
   logic       sel_ok;
   logic       done_p0, done_p1;
   logic [3:0] stb_q;
   logic       enter_select;

   // Stage p0/p1: two-flop synchronisers; p2 on sck/ss gives edge detection.
   // ss flops clear to 0 so a frame is only recognised after a fresh high-to-low on ss_n.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ss_p0   <= 1'b0;
         ss_p1   <= 1'b0;
         ss_p2   <= 1'b0;
         sck_p0  <= 1'b0;
         sck_p1  <= 1'b0;
         sck_p2  <= 1'b0;
         mosi_p0 <= 1'b0;
         mosi_p1 <= 1'b0;
      end else begin
         ss_p0   <= spi_ss_n;
         ss_p1   <= ss_p0;
         ss_p2   <= ss_p1;
         sck_p0  <= spi_sck;
         sck_p1  <= sck_p0;
         sck_p2  <= sck_p1;
         mosi_p0 <= spi_mosi;
         mosi_p1 <= mosi_p0;
      end
   end

   assign sck_rise = sck_p1 & ~sck_p2;
   assign sck_fall = ~sck_p1 & sck_p2;
   assign ss_fall  = ss_p2 & ~ss_p1;
   assign rx_next  = {rx[DATA_W-2:0], mosi_p1};
   assign byte_done = (state_q != IDLE) && !ss_p1 && sck_rise && (bit_cnt == LAST_BIT);

   always_comb begin
      id_hit = 1'b1;
      id_idx = 2'd0;
      if (rx_next == SYS_ID)      id_idx = 2'd0;
      else if (rx_next == HID_ID) id_idx = 2'd1;
      else if (rx_next == OSD_ID) id_idx = 2'd2;
      else if (rx_next == SDC_ID) id_idx = 2'd3;
      else                        id_hit = 1'b0;
   end

   always_comb begin
      din_sel = '0;
      if (sel_ok) begin
         case (sel_idx)
            2'd0: din_sel = sys_din;
            2'd1: din_sel = hid_din;
            2'd2: din_sel = osd_din;
            2'd3: din_sel = sdc_din;
            default: din_sel = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      strobe_en = 1'b0;
      start_d   = 1'b0;
      case (state_q)
         IDLE:    if (ss_fall) state_d = SELECT;
         SELECT:  if (byte_done) state_d = id_hit ? CMD : DISCARD;
         CMD: begin
            if (byte_done) begin
               state_d   = DATA;
               strobe_en = 1'b1;
               start_d   = 1'b1;
            end
         end
         DATA:    if (byte_done) strobe_en = 1'b1;
         DISCARD: state_d = DISCARD;
         default: state_d = IDLE;
      endcase
      if (ss_p1) begin
         state_d   = IDLE;
         strobe_en = 1'b0;
      end
   end

   assign enter_select = (state_q == IDLE) && (state_d == SELECT);

   // Stage: bit assembly, counted only while a frame is active.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bit_cnt <= '0;
         rx      <= '0;
      end else if (ss_p1 || state_q == IDLE) begin
         bit_cnt <= '0;
         rx      <= '0;
      end else if (sck_rise) begin
         rx      <= rx_next;
         bit_cnt <= bit_cnt + CNT_W'(1);
      end
   end

   // Stage: byte-complete routing; done_p0/done_p1 delay the reply load two cycles past the strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stb_q      <= '0;
         data_out   <= '0;
         data_start <= 1'b0;
         sel_idx    <= 2'd0;
         sel_ok     <= 1'b0;
         done_p0    <= 1'b0;
         done_p1    <= 1'b0;
      end else begin
         done_p0 <= byte_done;
         done_p1 <= ss_p1 ? 1'b0 : done_p0;
         stb_q   <= strobe_en ? (4'b0001 << sel_idx) : 4'b0000;
         if (state_q == SELECT && byte_done) begin
            sel_idx <= id_idx;
            sel_ok  <= id_hit;
         end else if (state_q == IDLE) begin
            sel_ok  <= 1'b0;
         end
         if (strobe_en) begin
            data_out   <= rx_next;
            data_start <= start_d;
         end
      end
   end

   // Stage: MISO shifter; the fall after the last rise of a byte leaves the freshly loaded reply intact.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx <= '0;
      end else if (ss_p1 || enter_select) begin
         tx <= '0;
      end else if (done_p1) begin
         tx <= din_sel;
      end else if (sck_fall && bit_cnt != '0) begin
         tx <= {tx[DATA_W-2:0], 1'b0};
      end
   end

   assign spi_miso   = tx[DATA_W-1];
   assign sys_strobe = stb_q[0];
   assign hid_strobe = stb_q[1];
   assign osd_strobe = stb_q[2];
   assign sdc_strobe = stb_q[3];

endmodule

// File: tb/tb_mcu_spi_target.sv
// Bench for mcu_spi_target: drives SPI frames, models routing/reply alignment per frame,
// and plays the four targets, answering each strobe with a scripted or random reply.
module tb_mcu_spi_target;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       spi_ss_n = 1'b1;
   logic       spi_sck = 1'b0;
   logic       spi_mosi = 1'b0;
   logic       spi_miso;
   logic [7:0] data_out;
   logic       data_start;
   logic       sys_strobe, hid_strobe, osd_strobe, sdc_strobe;
   logic [7:0] din_arr [4];

   mcu_spi_target dut (
      .clk        (clk),
      .reset      (reset),
      .spi_ss_n   (spi_ss_n),
      .spi_sck    (spi_sck),
      .spi_mosi   (spi_mosi),
      .spi_miso   (spi_miso),
      .data_out   (data_out),
      .data_start (data_start),
      .sys_strobe (sys_strobe),
      .hid_strobe (hid_strobe),
      .osd_strobe (osd_strobe),
      .sdc_strobe (sdc_strobe),
      .sys_din    (din_arr[0]),
      .hid_din    (din_arr[1]),
      .osd_din    (din_arr[2]),
      .sdc_din    (din_arr[3])
   );

   always #5 clk = ~clk;

   wire [3:0] stbv = {sdc_strobe, osd_strobe, hid_strobe, sys_strobe};

   typedef struct packed {
      logic [3:0] vec;
      logic [7:0] d;
      logic       s;
   } ev_t;

   int         n_vec = 0;
   int         n_err = 0;
   ev_t        evq [$];
   logic [7:0] given [$];
   logic [7:0] fr_tx [$];
   logic [7:0] fr_rx [$];
   logic [7:0] script [4];
   int         script_len = 0;
   int         frame_id = 0;
   int         seen_frame = 0;
   int         reply_idx = 0;
   logic       pend = 1'b0;
   int         pend_t = 0;
   logic [7:0] m_data = 8'h00;
   logic       m_start = 1'b0;
   logic [7:0] din0 [4];
   int         ev_base, g_base;

   // Target stand-in: logs every strobe cycle and answers one cycle later.
   always begin
      @(posedge clk);
      #1;
      if (seen_frame != frame_id) begin
         for (int t = 0; t < 4; t++) din_arr[t] = 8'($urandom);
         reply_idx  = 0;
         seen_frame = frame_id;
      end
      if (pend) begin
         if (reply_idx < script_len) din_arr[pend_t] = script[reply_idx];
         else                        din_arr[pend_t] = 8'($urandom);
         reply_idx++;
         given.push_back(din_arr[pend_t]);
         pend = 1'b0;
      end
      if (!reset && stbv != 4'b0000) begin
         evq.push_back('{vec: stbv, d: data_out, s: data_start});
         pend   = 1'b1;
         pend_t = stbv[0] ? 0 : stbv[1] ? 1 : stbv[2] ? 2 : 3;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_bits(input logic [7:0] b, input int nb, output logic [7:0] m);
      m = 8'h00;
      for (int k = 0; k < nb; k++) begin
         spi_mosi = b[7-k];
         repeat (5) @(negedge clk);
         m[7-k] = spi_miso;
         spi_sck = 1'b1;
         repeat (5) @(negedge clk);
         spi_sck = 1'b0;
      end
   endtask

   task automatic open_frame();
      frame_id++;
      fr_rx.delete();
      repeat (3) @(negedge clk);
      spi_ss_n = 1'b0;
      repeat (6) @(negedge clk);
      ev_base = evq.size();
      g_base  = given.size();
      for (int t = 0; t < 4; t++) din0[t] = din_arr[t];
   endtask

   task automatic close_frame();
      repeat (4) @(negedge clk);
      spi_ss_n = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   // Sends fr_tx; a nonzero part_bits cuts the last byte short to that many bits.
   task automatic do_frame(input int part_bits);
      logic [7:0] m;
      open_frame();
      for (int i = 0; i < fr_tx.size(); i++) begin
         send_bits(fr_tx[i], (part_bits != 0 && i == fr_tx.size() - 1) ? part_bits : 8, m);
         fr_rx.push_back(m);
      end
      close_frame();
   endtask

   task automatic check_frame(input string tag, input int nfull);
      int         tgt, nexp, got, gi;
      logic       valid;
      logic [7:0] exp_m;
      tgt   = int'(fr_tx[0]);
      valid = (tgt >= 1 && tgt <= 4);
      nexp  = valid ? nfull - 1 : 0;
      got   = evq.size() - ev_base;
      chk({tag, "_nstrobe"}, got, nexp);
      for (int j = 0; j < nexp && j < got; j++) begin
         chk({tag, "_vec"},   evq[ev_base+j].vec, 4'b0001 << (tgt - 1));
         chk({tag, "_data"},  evq[ev_base+j].d,   fr_tx[j+1]);
         chk({tag, "_start"}, evq[ev_base+j].s,   (j == 0));
         m_data  = fr_tx[j+1];
         m_start = (j == 0);
      end
      for (int k = 0; k < nfull; k++) begin
         if (k == 0 || !valid) exp_m = 8'h00;
         else if (k == 1)      exp_m = din0[tgt-1];
         else begin
            gi = g_base + k - 2;
            exp_m = (gi < given.size()) ? given[gi] : 8'hxx;
         end
         chk({tag, "_miso"}, fr_rx[k], exp_m);
      end
      chk({tag, "_dout"},  data_out,   m_data);
      chk({tag, "_dstart"}, data_start, m_start);
      chk({tag, "_idle_miso"}, spi_miso, 1'b0);
   endtask

   initial begin
      logic [7:0] m;
      int         r, len;

      repeat (4) @(negedge clk);
      chk("rst_miso",   spi_miso,   1'b0);
      chk("rst_dout",   data_out,   8'h00);
      chk("rst_dstart", data_start, 1'b0);
      chk("rst_stb",    stbv,       4'b0000);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      // Status query with scripted system-control replies.
      script[0] = 8'h5C; script[1] = 8'h42; script[2] = 8'h01; script_len = 3;
      fr_tx = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
      do_frame(0);
      check_frame("status", 5);
      chk("status_b2", fr_rx[2], 8'h5C);
      chk("status_b3", fr_rx[3], 8'h42);
      chk("status_b4", fr_rx[4], 8'h01);
      script_len = 0;

      for (int t = 2; t <= 4; t++) begin
         fr_tx = '{8'(t), 8'hA5, 8'h3C};
         do_frame(0);
         check_frame("route", 3);
      end

      fr_tx = '{8'h07, 8'h11, 8'h22};
      do_frame(0);
      check_frame("invalid", 3);

      // Abort five bits into the second payload byte.
      fr_tx = '{8'h01, 8'h3C, 8'hC3};
      do_frame(5);
      check_frame("abort", 2);
      fr_tx = '{8'h01, 8'h99};
      do_frame(0);
      check_frame("after_abort", 2);

      for (int f = 0; f < 6; f++) begin
         r = $urandom_range(0, 9);
         fr_tx.delete();
         if (r < 6) fr_tx.push_back(8'(1 + (r % 4)));
         else if (r == 6) fr_tx.push_back(8'h00);
         else fr_tx.push_back(8'($urandom_range(5, 255)));
         len = $urandom_range(1, 4);
         for (int i = 0; i < len; i++) fr_tx.push_back(8'($urandom));
         do_frame(0);
         check_frame("random", len + 1);
      end

      // Latency: strobe on the third edge after the last rise is registered, one cycle wide.
      open_frame();
      send_bits(8'h01, 8, m);
      send_bits(8'h5A, 7, m);
      spi_mosi = 1'b0;
      repeat (5) @(negedge clk);
      spi_sck = 1'b1;
      @(posedge clk); #1 chk("lat_e0", sys_strobe, 1'b0);
      @(posedge clk); #1 chk("lat_e1", sys_strobe, 1'b0);
      @(posedge clk); #1 chk("lat_e2", sys_strobe, 1'b1);
      chk("lat_dout",   data_out,   8'h5A);
      chk("lat_dstart", data_start, 1'b1);
      @(posedge clk); #1 chk("lat_e3", sys_strobe, 1'b0);
      repeat (2) @(negedge clk);
      spi_sck = 1'b0;
      m_data  = 8'h5A;
      m_start = 1'b1;
      close_frame();

      // Reset during the third byte.
      open_frame();
      send_bits(8'h01, 8, m);
      send_bits(8'hAA, 8, m);
      send_bits(8'hF0, 4, m);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("mrst_dout",   data_out,   8'h00);
      chk("mrst_dstart", data_start, 1'b0);
      chk("mrst_miso",   spi_miso,   1'b0);
      chk("mrst_stb",    stbv,       4'b0000);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      m_data  = 8'h00;
      m_start = 1'b0;
      ev_base = evq.size();
      send_bits(8'hF0, 4, m);
      send_bits(8'h02, 8, m);
      chk("mrst_nostrobe", evq.size() - ev_base, 0);
      chk("mrst_dout2",    data_out,             8'h00);
      close_frame();
      fr_tx = '{8'h02, 8'h77};
      do_frame(0);
      check_frame("post_reset", 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
